ctrl: RTL and testbench

CTRL -- requirements
Module: ctrl

---
 rtl/ctrl.sv | 167 ++++++++++++++++
 tb/tb_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ctrl
// Purpose  : Serial control-register loader. A host shifts 24-bit frames
//            (8-bit command, 16-bit value, MSB first) on ctrl_clk_i /
//            ctrl_data_i. Both are oversampled in the clk_i domain, and a
//            completed frame sets, ORs, clears or XORs the value into ctrl_o.
// Ports    : clk_i          system clock (only clock of the block)
//            reset_n_i      asynchronous active-low reset
//            ctrl_clk_i     serial clock from host (sampled as data)
//            ctrl_data_i    serial data, valid on ctrl_clk_i rising edge
//            ctrl_o         16-bit control register
//            ctrl_update_o  one-cycle pulse when ctrl_o takes a frame value
// Revision : 1.0 - initial release
// ============================================================================
module ctrl #(
    parameter int          TIMEOUT     = 1024,
    parameter logic [15:0] RESET_VALUE = 16'h0001
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        ctrl_clk_i,
    input  logic        ctrl_data_i,
    output logic [15:0] ctrl_o,
    output logic        ctrl_update_o
);

    localparam int                  c_IDLE_W   = $clog2(TIMEOUT);
    localparam logic [c_IDLE_W-1:0] c_IDLE_MAX = c_IDLE_W'(TIMEOUT - 1);
    localparam logic [4:0]          c_LAST_BIT = 5'd23;
    localparam logic [7:0]          c_CMD_SET  = 8'h00;
    localparam logic [7:0]          c_CMD_OR   = 8'h01;
    localparam logic [7:0]          c_CMD_CLR  = 8'h02;
    localparam logic [7:0]          c_CMD_XOR  = 8'h03;

    // ------------------------------------------------------------------
    // Two-flop synchronizers: index 0 = serial clock, index 1 = data
    // ------------------------------------------------------------------
    logic [1:0] w_raw;
    logic [1:0] w_sync;

    assign w_raw = {ctrl_data_i, ctrl_clk_i};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic r_meta;
            logic r_sync;

            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    r_meta <= 1'b0;
                    r_sync <= 1'b0;
                end else begin
                    r_meta <= w_raw[gi];
                    r_sync <= r_meta;
                end
            end

            assign w_sync[gi] = r_sync;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Edge detection
    // The synchronizer comes out of reset at 0, so a serial clock held
    // high across reset release would look like a 0->1 transition. r_vld
    // marks when the synchronizer holds real samples; edges are armed
    // only after a genuine low level has been seen from then on.
    // ------------------------------------------------------------------
    logic       r_clk_prev;
    logic [1:0] r_vld;
    logic       r_armed;
    logic       w_edge;

    assign w_edge = w_sync[0] & ~r_clk_prev & r_armed;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_clk_prev <= 1'b0;
            r_vld      <= 2'b00;
            r_armed    <= 1'b0;
        end else begin
            r_clk_prev <= w_sync[0];
            r_vld      <= {r_vld[0], 1'b1};
            if (r_vld[1] && !w_sync[0]) begin
                r_armed <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame assembly and command decode
    // ------------------------------------------------------------------
    logic [23:0]         r_shift;
    logic [4:0]          r_bit_cnt;
    logic [c_IDLE_W-1:0] r_idle;
    logic [15:0]         r_ctrl;
    logic                r_update;

    logic [23:0]         w_shift_nxt;
    logic [7:0]          w_cmd;
    logic [15:0]         w_value;
    logic                w_last;
    logic                w_timeout;
    logic                w_cmd_ok;
    logic [15:0]         w_ctrl_nxt;
    logic                w_unused_msb;

    // The oldest bit falls off the top when the next bit is shifted in;
    // the committed frame is taken from the post-shift value.
    assign w_shift_nxt  = {r_shift[22:0], w_sync[1]};
    assign w_unused_msb = r_shift[23];
    assign w_cmd        = w_shift_nxt[23:16];
    assign w_value      = w_shift_nxt[15:0];
    assign w_last       = w_edge && (r_bit_cnt == c_LAST_BIT);
    // An edge in the timeout cycle takes precedence over the timeout.
    assign w_timeout    = !w_edge && (r_bit_cnt != 5'd0) && (r_idle == c_IDLE_MAX);

    always_comb begin
        w_cmd_ok   = 1'b1;
        w_ctrl_nxt = r_ctrl;
        case (w_cmd)
            c_CMD_SET: w_ctrl_nxt = w_value;
            c_CMD_OR:  w_ctrl_nxt = r_ctrl | w_value;
            c_CMD_CLR: w_ctrl_nxt = r_ctrl & ~w_value;
            c_CMD_XOR: w_ctrl_nxt = r_ctrl ^ w_value;
            default:   w_cmd_ok   = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_idle    <= '0;
            r_ctrl    <= RESET_VALUE;
            r_update  <= 1'b0;
        end else begin
            r_update <= 1'b0;
            if (w_edge) begin
                r_shift <= w_shift_nxt;
                r_idle  <= '0;
                if (w_last) begin
                    r_bit_cnt <= '0;
                    if (w_cmd_ok) begin
                        r_ctrl   <= w_ctrl_nxt;
                        r_update <= 1'b1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
            end else if (w_timeout) begin
                r_bit_cnt <= '0;
                r_idle    <= '0;
            end else if (r_bit_cnt == 5'd0) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + c_IDLE_W'(1);
            end
        end
    end

    assign ctrl_o        = r_ctrl;
    assign ctrl_update_o = r_update;

endmodule
`default_nettype wire

// File: tb/tb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl
// Purpose  : Directed self-checking bench for ctrl. Frames are bit-banged
//            at clk_i/8 (4 cycles low, 4 cycles high) and results are
//            compared against hand-computed values.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl;

    localparam int c_TIMEOUT = 16;

    logic        clk_i       = 1'b0;
    logic        reset_n_i   = 1'b0;
    logic        ctrl_clk_i  = 1'b0;
    logic        ctrl_data_i = 1'b0;
    logic [15:0] ctrl_o;
    logic        ctrl_update_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          upd_cnt  = 0;
    int          u0;
    logic [3:0]  upd_seq;

    ctrl #(
        .TIMEOUT     (c_TIMEOUT),
        .RESET_VALUE (16'h0001)
    ) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .ctrl_clk_i    (ctrl_clk_i),
        .ctrl_data_i   (ctrl_data_i),
        .ctrl_o        (ctrl_o),
        .ctrl_update_o (ctrl_update_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (ctrl_update_o) upd_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; returns just after a negedge.
    // upd_seq[k] records ctrl_update_o at the k+1-th negedge after the rise.
    task automatic send_bit(input logic b);
        ctrl_clk_i  = 1'b0;
        ctrl_data_i = b;
        repeat (4) @(negedge clk_i);
        ctrl_clk_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            upd_seq[k] = ctrl_update_o;
        end
    endtask

    task automatic send_bits(input logic [23:0] f, input int n);
        for (int i = 0; i < n; i++) send_bit(f[23 - i]);
    endtask

    task automatic send_frame(input logic [23:0] f);
        send_bits(f, 24);
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        check_eq("rst_ctrl", 32'(ctrl_o), 32'h0001);
        check_eq("rst_upd", 32'(ctrl_update_o), 32'h0);
        reset_n_i = 1'b1;
        repeat (3) @(negedge clk_i);

        // Plain set; pulse on the 3rd edge after the final raw rise
        u0 = upd_cnt;
        send_frame(24'h00_0012);
        check_eq("set_0012", 32'(ctrl_o), 32'h0012);
        check_eq("set_latency", 32'(upd_seq), 32'b0100);
        check_eq("set_pulses", 32'(upd_cnt - u0), 32'd1);

        // OR then clear
        u0 = upd_cnt;
        send_frame(24'h01_0001);
        check_eq("or_0013", 32'(ctrl_o), 32'h0013);
        send_frame(24'h02_0010);
        check_eq("clr_0003", 32'(ctrl_o), 32'h0003);
        check_eq("or_clr_pulses", 32'(upd_cnt - u0), 32'd2);

        // XOR
        send_frame(24'h03_0005);
        check_eq("xor_0006", 32'(ctrl_o), 32'h0006);

        // Unknown command: no change, no pulse
        u0 = upd_cnt;
        send_frame(24'h7F_FFFF);
        check_eq("bad_cmd_val", 32'(ctrl_o), 32'h0006);
        check_eq("bad_cmd_seq", 32'(upd_seq), 32'b0000);
        check_eq("bad_cmd_pulses", 32'(upd_cnt - u0), 32'd0);
        send_frame(24'h00_0002);
        check_eq("after_bad_0002", 32'(ctrl_o), 32'h0002);

        // Valid command that leaves the value unchanged still pulses
        u0 = upd_cnt;
        send_frame(24'h01_0000);
        check_eq("same_val", 32'(ctrl_o), 32'h0002);
        check_eq("same_val_pulse", 32'(upd_cnt - u0), 32'd1);

        // Partial frame discarded by timeout
        send_bits(24'hFF_FFFF, 10);
        repeat (c_TIMEOUT + 2) @(negedge clk_i);
        check_eq("timeout_hold", 32'(ctrl_o), 32'h0002);
        send_frame(24'h00_00AA);
        check_eq("timeout_00AA", 32'(ctrl_o), 32'h00AA);

        // Short pause mid-frame stays well inside the timeout
        send_bits(24'h00_0155, 10);
        repeat (4) @(negedge clk_i);
        for (int i = 10; i < 24; i++) send_bit(24'h00_0155 >> (23 - i));
        check_eq("pause_0155", 32'(ctrl_o), 32'h0155);

        // Reset mid-frame, serial clock left high across release
        send_bits(24'h00_FFFF, 12);
        reset_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check_eq("midrst_ctrl", 32'(ctrl_o), 32'h0001);
        check_eq("midrst_upd", 32'(ctrl_update_o), 32'h0);
        reset_n_i = 1'b1;
        repeat (3) @(negedge clk_i);
        send_frame(24'h00_0005);
        check_eq("midrst_0005", 32'(ctrl_o), 32'h0005);

        // Serial clock held high through reset: no spurious edge
        ctrl_clk_i = 1'b1;
        reset_n_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        reset_n_i = 1'b1;
        repeat (6) @(negedge clk_i);
        check_eq("hold_hi_rst", 32'(ctrl_o), 32'h0001);
        u0 = upd_cnt;
        send_frame(24'h00_0003);
        check_eq("hold_hi_0003", 32'(ctrl_o), 32'h0003);
        check_eq("hold_hi_pulses", 32'(upd_cnt - u0), 32'd1);

        repeat (4) @(negedge clk_i);
        check_eq("final_upd_low", 32'(ctrl_update_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
